// File: rtl/btn_debounce.sv
// btn_debounce: synchronizes a noisy level input and accepts a new level only after
// STABLE_CYCLES+1 consecutive matching samples, counting aborted qualifications.
module btn_debounce #(
  parameter int STABLE_CYCLES = 16,
  parameter int GLITCH_W      = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                noisy_in,
  input  logic                glitch_clr,
  output logic                debounced,
  output logic                settling,
  output logic [GLITCH_W-1:0] glitch_cnt
);
  localparam int CW = STABLE_CYCLES > 2 ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
  // bit 0 of the encoding marks the WAIT states, so settling is a plain flop output
  typedef enum logic [1:0] {
    IDLE_LOW  = 2'b00,
    WAIT_HIGH = 2'b01,
    IDLE_HIGH = 2'b10,
    WAIT_LOW  = 2'b11
  } state_e;
  state_e state_q, state_d;
  logic sync1_q, s_q, deb_q, deb_d, abort, target;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GLITCH_W-1:0] glitch_q, glitch_d;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    deb_d   = deb_q;
    abort   = 1'b0;
    target  = state_q == WAIT_HIGH;
    case (state_q)
      IDLE_LOW:  if (s_q) begin state_d = WAIT_HIGH; cnt_d = '0; end
      IDLE_HIGH: if (!s_q) begin state_d = WAIT_LOW; cnt_d = '0; end
      default:
        if (s_q != target) begin
          state_d = target ? IDLE_LOW : IDLE_HIGH;
          cnt_d   = '0;
          abort   = 1'b1;
        end else if (cnt_q == LAST) begin
          state_d = target ? IDLE_HIGH : IDLE_LOW;
          deb_d   = target;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
    endcase
    glitch_d = glitch_clr ? '0 : (abort && glitch_q != '1) ? glitch_q + 1'b1 : glitch_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      s_q      <= 1'b0;
      state_q  <= IDLE_LOW;
      cnt_q    <= '0;
      deb_q    <= 1'b0;
      glitch_q <= '0;
    end else begin
      sync1_q  <= noisy_in;
      s_q      <= sync1_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      deb_q    <= deb_d;
      glitch_q <= glitch_d;
    end
  end
  assign debounced  = deb_q;
  assign settling   = state_q[0];
  assign glitch_cnt = glitch_q;
endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: three debouncer instances (4/8, 4/2, 16/8) checked every cycle
// against a run-length reference model, plus directed tables and corner sequences.
module tb_btn_debounce;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [2:0] noisy = '0, clr = '0, deb, set;
  logic [7:0] g0, g2;
  logic [1:0] g1;
  always #5 clk = ~clk;
  btn_debounce #(.STABLE_CYCLES(4), .GLITCH_W(8)) u0 (.clk(clk), .rst_n(rst_n), .noisy_in(noisy[0]),
    .glitch_clr(clr[0]), .debounced(deb[0]), .settling(set[0]), .glitch_cnt(g0));
  btn_debounce #(.STABLE_CYCLES(4), .GLITCH_W(2)) u1 (.clk(clk), .rst_n(rst_n), .noisy_in(noisy[1]),
    .glitch_clr(clr[1]), .debounced(deb[1]), .settling(set[1]), .glitch_cnt(g1));
  btn_debounce #(.STABLE_CYCLES(16), .GLITCH_W(8)) u2 (.clk(clk), .rst_n(rst_n), .noisy_in(noisy[2]),
    .glitch_clr(clr[2]), .debounced(deb[2]), .settling(set[2]), .glitch_cnt(g2));
  int checks = 0, failures = 0;
  int sc[3] = '{4, 4, 16};
  int gmax[3] = '{255, 3, 255};
  bit m_sy[3], m_s[3], m_db[3];
  int m_rl[3], m_gc[3];
  bit last_x2, prev_deb2, prev_set2;
  int stable_run, changes2;
  typedef struct {bit n; bit c; bit d; bit st; int g;} vec_t;
  vec_t tbl[$];
  function automatic int gval(int i);
    return i == 0 ? int'(g0) : i == 1 ? int'(g1) : int'(g2);
  endfunction
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_sy[i] = 0; m_s[i] = 0; m_db[i] = 0; m_rl[i] = 0; m_gc[i] = 0;
    end
    last_x2 = 0; stable_run = 0;
  endtask
  // Model: the accepted level flips once the sampled input has differed from it
  // for STABLE+1 consecutive samples; a shorter differing run is one glitch.
  task automatic step();
    bit x, gl;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      x = m_s[i]; m_s[i] = m_sy[i]; m_sy[i] = noisy[i]; gl = 0;
      if (x != m_db[i]) begin
        m_rl[i]++;
        if (m_rl[i] == sc[i] + 1) begin m_db[i] = x; m_rl[i] = 0; end
      end else begin
        gl = m_rl[i] > 0; m_rl[i] = 0;
      end
      if (clr[i]) m_gc[i] = 0;
      else if (gl && m_gc[i] < gmax[i]) m_gc[i]++;
      if (i == 2) begin
        stable_run = (x == last_x2) ? stable_run + 1 : 1;
        last_x2 = x;
      end
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("deb%0d", i), int'(deb[i]), int'(m_db[i]));
      chk($sformatf("settling%0d", i), int'(set[i]), int'(m_rl[i] > 0));
      chk($sformatf("glitch%0d", i), gval(i), m_gc[i]);
    end
    if (deb[2] != prev_deb2) begin
      changes2++;
      chk("soak_settling_before_change", int'(prev_set2), 1);
      chk("soak_stable_run_ge17", int'(stable_run >= 17), 1);
    end
    prev_deb2 = deb[2]; prev_set2 = set[2];
  endtask
  task automatic edges_until(int i, bit v, output int n);
    n = 0;
    while (deb[i] != v && n < 60) begin step(); n++; end
  endtask
  task automatic add(bit n, bit c, bit d, bit st, int g);
    vec_t v;
    v.n = n; v.c = c; v.d = d; v.st = st; v.g = g;
    tbl.push_back(v);
  endtask
  initial begin
    int n, left[3];
    bit rise[8] = '{0, 0, 0, 0, 0, 0, 1, 1};
    bit rset[8] = '{0, 0, 1, 1, 1, 1, 0, 0};
    for (int k = 0; k < 8; k++) add(1, 0, rise[k], rset[k], 0);
    for (int k = 0; k < 8; k++) add(0, 0, !rise[k], rset[k], 0);
    add(1, 0, 0, 0, 0); add(1, 0, 0, 0, 0); add(1, 0, 0, 1, 0);
    add(0, 0, 0, 1, 0); add(0, 0, 0, 1, 0); add(0, 0, 0, 0, 1); add(0, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0); add(0, 0, 0, 0, 0);
    model_reset();
    changes2 = 0; prev_deb2 = 0; prev_set2 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_deb", int'(deb[0]), 0);
    chk("reset_settling", int'(set[0]), 0);
    chk("reset_glitch", int'(g0), 0);
    rst_n = 1'b1;
    foreach (tbl[k]) begin
      noisy[1:0] = {2{tbl[k].n}}; clr[1:0] = {2{tbl[k].c}};
      step();
      chk($sformatf("tbl%0d_deb", k), int'(deb[0]), int'(tbl[k].d));
      chk($sformatf("tbl%0d_settling", k), int'(set[0]), int'(tbl[k].st));
      chk($sformatf("tbl%0d_glitch", k), int'(g0), tbl[k].g);
    end
    clr = '0;
    for (int k = 0; k < 4; k++) begin
      noisy[0] = (k % 2 == 0);
      step();
      chk("bounce_hold_low", int'(deb[0]), 0);
    end
    noisy[0] = 1;
    edges_until(0, 1, n);
    chk("bounce_rise_latency", n, 7);
    chk("bounce_aborts", int'(g0), 2);
    noisy[0] = 0;
    edges_until(0, 0, n);
    chk("fall_latency", n, 7);
    for (int k = 0; k < 5; k++) begin
      noisy[1] = 1; step();
      noisy[1] = 0; repeat (3) step();
    end
    chk("glitch_saturate", int'(g1), 3);
    noisy[1] = 1; step();
    noisy[1] = 0; step(); step();
    chk("pre_abort_settling", int'(set[1]), 1);
    clr[1] = 1; step(); clr[1] = 0;
    chk("clear_wins_glitch", int'(g1), 0);
    chk("clear_abort_settling", int'(set[1]), 0);
    noisy[0] = 1;
    repeat (5) step();
    chk("mid_wait_settling", int'(set[0]), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_deb", int'(deb[0]), 0);
    chk("async_rst_settling", int'(set[0]), 0);
    chk("async_rst_glitch", int'(g0), 0);
    model_reset();
    #2 rst_n = 1'b1;
    edges_until(0, 1, n);
    chk("post_reset_latency", n, 7);
    noisy[0] = 0;
    edges_until(0, 0, n);
    chk("post_reset_fall", n, 7);
    left = '{0, 0, 0};
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (left[i] == 0) begin
          noisy[i] = ~noisy[i];
          left[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(18, 40) : $urandom_range(1, 6);
        end
        left[i]--;
        clr[i] = ($urandom_range(0, 199) == 0);
      end
      step();
    end
    chk("soak_accepts_seen", int'(changes2 > 10), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 16: the number of consecutive synchronized samples required in a WAIT state before a level change is accepted. The legal range is 2..65535.
REQ-002 SHALL have parameter GLITCH_W, default 8: the width of the glitch counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all flops are rising-edge triggered.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port noisy_in, input, 1 bit: raw asynchronous mechanical/external input.
REQ-006 SHALL have port glitch_clr, input, 1 bit: synchronous clear of glitch_cnt.
REQ-007 SHALL have port debounced, output, 1 bit: the clean registered level, intended to feed the downstream edge detector.
REQ-008 SHALL have port settling, output, 1 bit: high while a candidate level change is being qualified.
REQ-009 SHALL have port glitch_cnt, output, GLITCH_W bits: the count of aborted qualifications.

Function
REQ-010 SHALL pass noisy_in through a 2-flop synchronizer (sync1 -> s). Only s feeds the remaining logic.
REQ-011 SHALL implement a 4-state FSM with states IDLE_LOW, WAIT_HIGH, IDLE_HIGH and WAIT_LOW.
REQ-012 SHALL, in IDLE_LOW with s=1, go to WAIT_HIGH with cnt<=0; with s=0 it stays.
REQ-013 SHALL, in IDLE_HIGH with s=0, go to WAIT_LOW with cnt<=0; with s=1 it stays.
REQ-014 SHALL, in WAIT_x with s equal to the target level and cnt != STABLE_CYCLES-1, apply cnt<=cnt+1.
REQ-015 SHALL, in WAIT_x with s equal to the target level and cnt == STABLE_CYCLES-1, go to IDLE_x and set debounced<=target on the same edge.
REQ-016 SHALL, in WAIT_x with s != target, abort to the previous IDLE state with cnt<=0, leave debounced unchanged, and increment glitch_cnt.
REQ-017 SHALL size cnt to $clog2(STABLE_CYCLES) bits, minimum 1. cnt never exceeds STABLE_CYCLES-1 and never wraps.
REQ-018 SHALL give a total latency of STABLE_CYCLES+3 rising edges from a clean input step to the debounced update, counting the first edge at which sync1 captures the new level. For example, STABLE_CYCLES=4 gives 7 edges.
REQ-019 SHALL drive settling high exactly while the state is WAIT_HIGH or WAIT_LOW, as registered state decode with no combinational path from noisy_in.
REQ-020 SHALL register debounced, so it changes only on clk edges and glitch-free, and holds at least STABLE_CYCLES+1 cycles between changes.
REQ-021 SHALL saturate glitch_cnt at 2^GLITCH_W-1 and not wrap.
REQ-022 SHALL make glitch_clr force glitch_cnt<=0 on the next edge. If an abort occurs in the same cycle, clear wins and the result is 0.
REQ-023 SHALL NOT generate edge pulses itself; edge pulse generation is the downstream stage's job.

Reset
REQ-024 SHALL, when rst_n=0, asynchronously force sync1=0, s=0, state=IDLE_LOW, cnt=0, debounced=0, settling=0 and glitch_cnt=0.
REQ-025 SHALL, on rst_n deassertion while noisy_in=1, make debounced rise only after a full qualification: STABLE_CYCLES+3 edges after the first post-release edge.
REQ-026 SHALL, when reset asserts mid-WAIT, abandon the qualification with no debounced change and no glitch_cnt increment.

Verification (STABLE_CYCLES=4, GLITCH_W=8 unless noted)
REQ-027 Clean rise: noisy_in steps 0->1 and is held; debounced=1 after exactly 7 edges and settling is high for 4 cycles. Falling step: same timing, debounced=0.
REQ-028 Bounce: noisy_in toggles 1,0,1,0 on successive cycles, then holds 1; debounced stays 0 during the bounce, then rises 7 edges after the final stable 1, and glitch_cnt equals the number of aborts observed.
REQ-029 Short pulse: a 3-cycle high pulse on noisy_in leaves debounced=0, and glitch_cnt increments by exactly 1.
REQ-030 Saturation/clear: with GLITCH_W=2, 5 aborts give glitch_cnt=3; pulsing glitch_clr in the same cycle as an abort gives glitch_cnt=0.
REQ-031 Reset mid-WAIT: assert rst_n=0 two cycles into WAIT_HIGH; all outputs are 0 immediately (asynchronously); after release with noisy_in=1, debounced rises after 7 edges.
REQ-032 Random bounce soak (10k cycles, STABLE_CYCLES=16): debounced never changes while settling=0, and every accepted level has been s-stable for at least 17 consecutive samples.
